// File: rtl/alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_arbiter
// Purpose  : Round-robin sharing of one pipelined 8-bit ALU among NUM_REQ
//            requesters; results come back tagged with the requester ID.
// Options  : ALU_ARB_DIV0_GUARD_EN - flag modulo-by-zero responses (resp_err_o)
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic                 clk_p_i,
    input  logic                 reset_p_i,
    input  logic                 enable_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    input  logic [8*NUM_REQ-1:0] req_data_a_i,
    input  logic [8*NUM_REQ-1:0] req_data_b_i,
    input  logic [3*NUM_REQ-1:0] req_inst_i,
    output logic [7:0]           alu_data_a_o,
    output logic [7:0]           alu_data_b_o,
    output logic [2:0]           alu_inst_o,
    input  logic [15:0]          alu_data_i,
    output logic                 resp_valid_o,
    output logic [ID_W-1:0]      resp_id_o,
    output logic [15:0]          resp_data_o,
`ifdef ALU_ARB_DIV0_GUARD_EN
    output logic                 resp_err_o,
`endif
    output logic                 busy_o
);

    localparam int             DEPTH   = ALU_LAT + 1;
    localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

    logic [ID_W-1:0]            ptr_q;
    logic                       gnt_found;
    logic                       gnt_en;
    logic [ID_W-1:0]            gnt_id;
    int                         cand;
    logic [7:0]                 sel_a;
    logic [7:0]                 sel_b;
    logic [2:0]                 sel_inst;

    logic [DEPTH-1:0]           pipe_vld_q;
    logic [DEPTH-1:0]           pipe_vld_d;
    logic [DEPTH-1:0][ID_W-1:0] pipe_id_q;
    logic [DEPTH-1:0][ID_W-1:0] pipe_id_d;

    logic [7:0]                 alu_a_q;
    logic [7:0]                 alu_b_q;
    logic [2:0]                 alu_inst_q;
    logic                       resp_valid_q;
    logic [ID_W-1:0]            resp_id_q;
    logic [15:0]                resp_data_q;
    logic                       busy_q;

    // Search starts just past the last winner, so the previous grantee has lowest priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(ptr_q) + i) % NUM_REQ;
            if (!gnt_found && req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = ID_W'(cand);
            end
        end
    end

    assign gnt_en   = enable_i & ~reset_p_i & gnt_found;
    assign sel_a    = req_data_a_i[8*gnt_id +: 8];
    assign sel_b    = req_data_b_i[8*gnt_id +: 8];
    assign sel_inst = req_inst_i[3*gnt_id +: 3];

    always_comb begin
        req_ready_o = '0;
        if (gnt_en) begin
            req_ready_o = NUM_REQ'(1) << gnt_id;
        end
    end

    assign pipe_vld_d = {pipe_vld_q[DEPTH-2:0], gnt_en};
    assign pipe_id_d  = {pipe_id_q[DEPTH-2:0], gnt_id};

`ifdef ALU_ARB_DIV0_GUARD_EN
    logic             sel_div0;
    logic [DEPTH-1:0] pipe_err_q;
    logic             resp_err_q;

    assign sel_div0 = (sel_inst == 3'b111) && (sel_a == 8'h00);

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            pipe_err_q <= '0;
            resp_err_q <= 1'b0;
        end else begin
            pipe_err_q <= {pipe_err_q[DEPTH-2:0], gnt_en & sel_div0};
            resp_err_q <= pipe_vld_q[DEPTH-1] & pipe_err_q[DEPTH-1];
        end
    end

    assign resp_err_o = resp_err_q;
`endif

    always_ff @(posedge clk_p_i) begin
        if (reset_p_i) begin
            ptr_q        <= PTR_RST;
            pipe_vld_q   <= '0;
            pipe_id_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_inst_q   <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            pipe_vld_q   <= pipe_vld_d;
            pipe_id_q    <= pipe_id_d;
            busy_q       <= |pipe_vld_d;
            resp_valid_q <= pipe_vld_q[DEPTH-1];
            if (gnt_en) begin
                ptr_q      <= gnt_id;
                alu_a_q    <= sel_a;
                alu_b_q    <= sel_b;
                alu_inst_q <= sel_inst;
            end
            if (pipe_vld_q[DEPTH-1]) begin
                resp_id_q <= pipe_id_q[DEPTH-1];
`ifdef ALU_ARB_DIV0_GUARD_EN
                resp_data_q <= pipe_err_q[DEPTH-1] ? 16'hFFFF : alu_data_i;
`else
                resp_data_q <= alu_data_i;
`endif
            end
        end
    end

    assign alu_data_a_o = alu_a_q;
    assign alu_data_b_o = alu_b_q;
    assign alu_inst_o   = alu_inst_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_data_o  = resp_data_q;
    assign busy_o       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_arbiter
// Purpose  : Table vectors, directed corner sequences and random traffic
//            checked against a queue-based reference model of alu_rr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int ALU_LAT = 1;

    typedef struct {
        logic                rst;
        logic                en;
        logic [NUM_REQ-1:0]  v;
        logic [NUM_REQ-1:0]  exp_rdy;
    } vec_t;

    typedef struct {
        int          id;
        logic [15:0] data;
        logic        err;
        int          due;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic                 en;
    logic [NUM_REQ-1:0]   vld;
    logic [7:0]           ra [NUM_REQ];
    logic [7:0]           rb [NUM_REQ];
    logic [2:0]           ri [NUM_REQ];
    logic [8*NUM_REQ-1:0] pa;
    logic [8*NUM_REQ-1:0] pb;
    logic [3*NUM_REQ-1:0] pi;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           alu_a;
    logic [7:0]           alu_b;
    logic [2:0]           alu_inst;
    logic [15:0]          alu_res;
    logic [15:0]          alu_pipe [ALU_LAT];
    logic                 resp_valid;
    logic [ID_W-1:0]      resp_id;
    logic [15:0]          resp_data;
    logic                 busy;
`ifdef ALU_ARB_DIV0_GUARD_EN
    logic                 resp_err;
`endif

    int   total;
    int   bad;
    int   cyc;
    int   mptr;
    int   last_acc;
    exp_t q[$];
    vec_t tbl [21];

    alu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .ALU_LAT(ALU_LAT)) dut (
        .clk_p_i      (clk),
        .reset_p_i    (rst),
        .enable_i     (en),
        .req_valid_i  (vld),
        .req_ready_o  (req_ready),
        .req_data_a_i (pa),
        .req_data_b_i (pb),
        .req_inst_i   (pi),
        .alu_data_a_o (alu_a),
        .alu_data_b_o (alu_b),
        .alu_inst_o   (alu_inst),
        .alu_data_i   (alu_res),
        .resp_valid_o (resp_valid),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
`ifdef ALU_ARB_DIV0_GUARD_EN
        .resp_err_o   (resp_err),
`endif
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        pa = '0;
        pb = '0;
        pi = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pa[8*k +: 8] = ra[k];
            pb[8*k +: 8] = rb[k];
            pi[3*k +: 3] = ri[k];
        end
    end

    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        logic [15:0] wa;
        logic [15:0] wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (op)
            3'd0:    return wa + wb;
            3'd1:    return wa - wb;
            3'd2:    return wa * wb;
            3'd3:    return wa & wb;
            3'd4:    return wa | wb;
            3'd5:    return wa ^ wb;
            3'd6:    return (b == 8'h00) ? 16'hBEEF : wa / wb;
            default: return (a == 8'h00) ? 16'hDEAD : wb % wa;
        endcase
    endfunction

    // Environment ALU with ALU_LAT edges of latency
    always @(posedge clk) begin
        alu_pipe[0] <= alu_fn(alu_a, alu_b, alu_inst);
        for (int s = 1; s < ALU_LAT; s++) alu_pipe[s] <= alu_pipe[s-1];
    end
    assign alu_res = alu_pipe[ALU_LAT-1];

    function automatic logic [15:0] exp_data(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] op);
`ifdef ALU_ARB_DIV0_GUARD_EN
        if (op == 3'b111 && a == 8'h00) return 16'hFFFF;
`endif
        return alu_fn(a, b, op);
    endfunction

    function automatic int model_grant();
        int c;
        if (rst || !en) return -1;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = (mptr + i) % NUM_REQ;
            if (vld[c]) return c;
        end
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Check the current window against the model, then advance one clock edge.
    task automatic tick();
        int   g;
        exp_t e;
        #1;
        g = model_grant();
        chk("ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_data", 32'(resp_data), 32'(e.data));
`ifdef ALU_ARB_DIV0_GUARD_EN
            chk("resp_err", 32'(resp_err), 32'(e.err));
`endif
        end else begin
            chk("resp_valid_idle", 32'(resp_valid), 32'd0);
        end
        chk("busy", 32'(busy), (q.size() > 0) ? 32'd1 : 32'd0);
        @(posedge clk);
        cyc++;
        last_acc = -1;
        if (rst) begin
            q.delete();
            mptr = NUM_REQ - 1;
        end else if (g >= 0) begin
            e.id   = g;
            e.data = exp_data(ra[g], rb[g], ri[g]);
            e.err  = (ri[g] == 3'b111) && (ra[g] == 8'h00);
            e.due  = cyc + ALU_LAT + 1;
            q.push_back(e);
            mptr     = g;
            last_acc = g;
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0; mptr = NUM_REQ - 1; last_acc = -1;
        rst = 1'b1; en = 1'b0; vld = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            ra[k] = 8'(8'h10 * k + 3);
            rb[k] = 8'(k + 1);
            ri[k] = 3'(k);
        end

        tbl[0]  = '{1'b1, 1'b1, 4'b1111, 4'b0000};
        tbl[1]  = '{1'b0, 1'b1, 4'b1111, 4'b0001};
        tbl[2]  = '{1'b0, 1'b1, 4'b1111, 4'b0010};
        tbl[3]  = '{1'b0, 1'b1, 4'b1111, 4'b0100};
        tbl[4]  = '{1'b0, 1'b1, 4'b1111, 4'b1000};
        tbl[5]  = '{1'b0, 1'b1, 4'b1111, 4'b0001};
        tbl[6]  = '{1'b0, 1'b1, 4'b1111, 4'b0010};
        tbl[7]  = '{1'b0, 1'b1, 4'b1111, 4'b0100};
        tbl[8]  = '{1'b0, 1'b1, 4'b1111, 4'b1000};
        tbl[9]  = '{1'b0, 1'b1, 4'b1001, 4'b0001};
        tbl[10] = '{1'b0, 1'b1, 4'b1001, 4'b1000};
        tbl[11] = '{1'b0, 1'b1, 4'b1001, 4'b0001};
        tbl[12] = '{1'b0, 1'b0, 4'b0010, 4'b0000};
        tbl[13] = '{1'b0, 1'b0, 4'b0010, 4'b0000};
        tbl[14] = '{1'b0, 1'b0, 4'b0010, 4'b0000};
        tbl[15] = '{1'b0, 1'b1, 4'b0010, 4'b0010};
        tbl[16] = '{1'b0, 1'b1, 4'b0100, 4'b0100};
        tbl[17] = '{1'b0, 1'b1, 4'b0100, 4'b0100};
        tbl[18] = '{1'b0, 1'b1, 4'b0000, 4'b0000};
        tbl[19] = '{1'b0, 1'b1, 4'b0000, 4'b0000};
        tbl[20] = '{1'b0, 1'b1, 4'b0000, 4'b0000};

        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 21; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            vld = tbl[i].v;
            #1;
            chk("tbl_ready", 32'(req_ready), 32'(tbl[i].exp_rdy));
            tick();
        end

        // Lone requester 2: 5 + 3 returns two edges after accept
        rst = 1'b1; vld = '0; tick(); rst = 1'b0; en = 1'b1;
        ra[2] = 8'h05; rb[2] = 8'h03; ri[2] = 3'b000; vld = 4'b0100;
        #1;
        chk("solo_ready", 32'(req_ready), 32'h4);
        tick();
        vld = '0;
        chk("solo_busy", 32'(busy), 32'd1);
        tick();
        chk("solo_not_yet", 32'(resp_valid), 32'd0);
        tick();
        chk("solo_valid", 32'(resp_valid), 32'd1);
        chk("solo_id", 32'(resp_id), 32'd2);
        chk("solo_data", 32'(resp_data), 32'h0008);
        chk("solo_busy_low", 32'(busy), 32'd0);

        // Modulo by zero on requester 1
        ra[1] = 8'h00; rb[1] = 8'h07; ri[1] = 3'b111; vld = 4'b0010;
        tick();
        vld = '0;
        tick();
        tick();
        chk("div0_valid", 32'(resp_valid), 32'd1);
        chk("div0_id", 32'(resp_id), 32'd1);
`ifdef ALU_ARB_DIV0_GUARD_EN
        chk("div0_data", 32'(resp_data), 32'hFFFF);
        chk("div0_err", 32'(resp_err), 32'd1);
`else
        chk("div0_data", 32'(resp_data), 32'hDEAD);
`endif

        // Reset with operations in flight discards them
        rst = 1'b1; tick(); rst = 1'b0;
        vld = 4'b0111;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        tick();
        rst = 1'b0; vld = '0;
        chk("rst_no_resp", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        chk("rst_no_resp2", 32'(resp_valid), 32'd0);
        vld = 4'b1111;
        #1;
        chk("rst_next_gnt", 32'(req_ready), 32'd1);
        tick();
        vld = '0;
        tick();
        tick();

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            en  = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < NUM_REQ; k++) begin
                if (vld[k] && last_acc != k) begin
                    if ($urandom_range(0, 15) == 0) vld[k] = 1'b0;
                end else begin
                    vld[k] = 1'($urandom_range(0, 1));
                    ra[k]  = 8'($urandom);
                    rb[k]  = 8'($urandom);
                    ri[k]  = 3'($urandom);
                    if ($urandom_range(0, 7) == 0) begin
                        ra[k] = 8'h00;
                        ri[k] = 3'b111;
                    end
                end
            end
            tick();
        end

        rst = 1'b0; en = 1'b1; vld = '0;
        for (int c = 0; c < 6; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
